// File: rtl/antiq_pkg.sv
// Shared types and helpers for the antiq priority queue.
//   entry_t     : slot layout {valid, key, id} at the default configuration widths
//   ORDER_*     : ordering encodings (max-first / min-first)
//   higher_prio : strict priority compare between two keys (keys up to KEY_MAX_W bits)
package antiq_pkg;

  localparam int unsigned KEY_MAX_W = 64;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_ID_W  = $clog2(DEF_DEPTH + 1);

  localparam int unsigned ORDER_MAX_FIRST = 0;
  localparam int unsigned ORDER_MIN_FIRST = 1;

  // The top re-declares this layout at its own parameterised widths.
  typedef struct packed {
    logic                valid;
    logic [DEF_DW-1:0]   key;
    logic [DEF_ID_W-1:0] id;
  } entry_t;

  // True when key a strictly outranks key b; ties return 0 so equal keys stay FIFO.
  function automatic logic higher_prio(input int unsigned        order,
                                       input logic [KEY_MAX_W-1:0] a,
                                       input logic [KEY_MAX_W-1:0] b);
    if (order == ORDER_MIN_FIRST) return a < b;
    return a > b;
  endfunction

endpackage

// File: rtl/antiq_id_alloc.sv
// ID allocator: free bitmap for IDs 1..DEPTH with lowest-free selection.
//   clk, rst   : clock, synchronous active-high reset (all IDs free)
//   release_en : an ID is being freed this cycle
//   release_id : ID being freed
//   alloc_en   : the offered ID is consumed this cycle
//   alloc_id_c : lowest free ID, counting one being released this cycle (0 = none)
module antiq_id_alloc
  import antiq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned ID_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            release_en,
  input  logic [ID_W-1:0] release_id,
  input  logic            alloc_en,
  output logic [ID_W-1:0] alloc_id_c
);

  logic [DEPTH-1:0] free_q;
  logic [DEPTH-1:0] avail;

  // A released ID is immediately available for reuse in the same cycle.
  always_comb begin
    avail      = '0;
    alloc_id_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      avail[i] = free_q[i] | (release_en & (release_id == ID_W'(i + 1)));
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (avail[i]) alloc_id_c = ID_W'(i + 1);
    end
  end

  // Bitmap update: bit i tracks ID i+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q <= '1;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        free_q[i] <= avail[i] & ~(alloc_en & (alloc_id_c == ID_W'(i + 1)));
      end
    end
  end

endmodule

// File: rtl/antiq_pq.sv
// Register-based sorted priority queue with recyclable IDs and overflow eviction.
// Slot 0 is the head; invalid slots are kept all-zero so an empty head reads 0.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   push_i, data_i       : push strobe and key; push_rdy_o is 1 outside reset
//   pop_i, pop_rdy_o     : pop strobe; ready when non-empty
//   drop_i, drop_id_i    : remove by ID; drop_rdy_o = ~push_i & ~pop_i
//   push_ack_o/push_id_o : pulse after a push with the assigned ID (0 = rejected)
//   drop_err_o           : pulse when the dropped ID was not present
//   data_o, head_id_o    : head key / ID
//   empty_o, full_o, cnt_o
//   overflow_o, data_overflow_o, overflow_id_o : pulse with the displaced key / ID
module antiq_pq
  import antiq_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned DW    = DEF_DW,
  parameter  int unsigned ORDER = ORDER_MAX_FIRST,
  localparam int unsigned ID_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [DW-1:0]   data_i,
  output logic            push_rdy_o,
  input  logic            pop_i,
  output logic            pop_rdy_o,
  input  logic            drop_i,
  input  logic [ID_W-1:0] drop_id_i,
  output logic            drop_rdy_o,
  output logic            push_ack_o,
  output logic [ID_W-1:0] push_id_o,
  output logic            drop_err_o,
  output logic [DW-1:0]   data_o,
  output logic [ID_W-1:0] head_id_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [ID_W-1:0] cnt_o,
  output logic            overflow_o,
  output logic [DW-1:0]   data_overflow_o,
  output logic [ID_W-1:0] overflow_id_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic            valid;
    logic [DW-1:0]   key;
    logic [ID_W-1:0] id;
  } slot_t;

  slot_t q     [DEPTH];
  slot_t shr   [DEPTH];
  slot_t q_nxt [DEPTH];
  slot_t new_ent;

  logic [ID_W-1:0]  cnt_q, cnt_nxt;
  logic             empty_q, full_q;
  logic             pop_acc, drop_acc, drop_hit, tail_wins;
  logic             evict, reject, ins_en, rem_en;
  logic [IDX_W-1:0] drop_idx, rem_idx, ins_pos;
  logic [ID_W-1:0]  rel_id, alloc_id_c;

  logic             push_ack_q, drop_err_q, ovf_q;
  logic [ID_W-1:0]  push_id_q, ovf_id_q;
  logic [DW-1:0]    ovf_data_q;

  antiq_id_alloc #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_id_alloc (
    .clk        (clk_i),
    .rst        (rst_i),
    .release_en (rem_en),
    .release_id (rel_id),
    .alloc_en   (ins_en),
    .alloc_id_c (alloc_id_c)
  );

  // Next-state: optional removal (pop / drop / eviction) then optional sorted insert.
  always_comb begin
    pop_acc  = pop_i & ~empty_q;
    drop_acc = drop_i & ~push_i & ~pop_i;

    drop_hit = 1'b0;
    drop_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (q[i].valid && (q[i].id == drop_id_i)) begin
        drop_hit = 1'b1;
        drop_idx = IDX_W'(i);
      end
    end

    // Push+pop on a full queue frees the head first, so no overflow there.
    tail_wins = higher_prio(ORDER, KEY_MAX_W'(data_i), KEY_MAX_W'(q[DEPTH-1].key));
    evict     = push_i & full_q & ~pop_acc & tail_wins;
    reject    = push_i & full_q & ~pop_acc & ~tail_wins;
    ins_en    = push_i & ~reject;
    rem_en    = pop_acc | (drop_acc & drop_hit) | evict;
    rem_idx   = pop_acc ? '0 : (evict ? IDX_W'(DEPTH - 1) : drop_idx);
    rel_id    = q[rem_idx].id;

    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      shr[i] = (rem_en && (IDX_W'(i) >= rem_idx)) ? q[i+1] : q[i];
    end
    shr[DEPTH-1] = rem_en ? '0 : q[DEPTH-1];

    new_ent.valid = 1'b1;
    new_ent.key   = data_i;
    new_ent.id    = alloc_id_c;

    // Strict compare places the new key behind equal keys.
    ins_pos = IDX_W'(DEPTH - 1);
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!shr[i].valid || higher_prio(ORDER, KEY_MAX_W'(data_i), KEY_MAX_W'(shr[i].key))) begin
        ins_pos = IDX_W'(i);
      end
    end

    q_nxt[0] = (ins_en && (ins_pos == '0)) ? new_ent : shr[0];
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (!ins_en || (IDX_W'(i) < ins_pos)) q_nxt[i] = shr[i];
      else if (IDX_W'(i) == ins_pos)        q_nxt[i] = new_ent;
      else                                  q_nxt[i] = shr[i-1];
    end

    cnt_nxt = cnt_q - ID_W'(rem_en) + ID_W'(ins_en);
  end

  // State and registered status/pulse outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      push_ack_q <= 1'b0;
      push_id_q  <= '0;
      drop_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_data_q <= '0;
      ovf_id_q   <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= q_nxt[i];
      cnt_q      <= cnt_nxt;
      empty_q    <= (cnt_nxt == '0);
      full_q     <= (cnt_nxt == ID_W'(DEPTH));
      push_ack_q <= push_i;
      push_id_q  <= ins_en ? alloc_id_c : '0;
      drop_err_q <= drop_acc & ~drop_hit;
      ovf_q      <= evict | reject;
      ovf_data_q <= evict ? q[DEPTH-1].key : (reject ? data_i : '0);
      ovf_id_q   <= evict ? q[DEPTH-1].id : '0;
    end
  end

  assign push_rdy_o      = ~rst_i;
  assign pop_rdy_o       = ~empty_q;
  assign drop_rdy_o      = ~push_i & ~pop_i;
  assign push_ack_o      = push_ack_q;
  assign push_id_o       = push_id_q;
  assign drop_err_o      = drop_err_q;
  assign data_o          = q[0].key;
  assign head_id_o       = q[0].id;
  assign empty_o         = empty_q;
  assign full_o          = full_q;
  assign cnt_o           = cnt_q;
  assign overflow_o      = ovf_q;
  assign data_overflow_o = ovf_data_q;
  assign overflow_id_o   = ovf_id_q;

endmodule
